// File: rtl/tex_texel_fetch.sv
// Texel fetch: per-lane/tap word reads, in-order tag FIFO, stride extraction.
// Optional perf counters are built only when TEX_FETCH_PERF_EN is defined.
module tex_texel_fetch #(
   parameter int NUM_LANES   = 4,
   parameter int REQ_INFOW   = 1,
   parameter int W_ADDR_BITS = 38,
   parameter int BLEND_FRAC  = 8,
   parameter int MAX_PENDING = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic [NUM_LANES-1:0]              req_mask,
   input  logic                              req_filter,
   input  logic [1:0]                        req_lgstride,
   input  logic [NUM_LANES*W_ADDR_BITS-1:0]  req_baseaddr,
   input  logic [NUM_LANES*4*32-1:0]         req_addr,
   input  logic [NUM_LANES*2*BLEND_FRAC-1:0] req_blends,
   input  logic [REQ_INFOW-1:0]              req_info,
   output logic                              mem_req_valid,
   input  logic                              mem_req_ready,
   output logic [W_ADDR_BITS-3:0]            mem_req_addr,
   input  logic                              mem_rsp_valid,
   output logic                              mem_rsp_ready,
   input  logic [31:0]                       mem_rsp_data,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [NUM_LANES-1:0]              rsp_mask,
   output logic [NUM_LANES*4*32-1:0]         rsp_texels,
   output logic [NUM_LANES*2*BLEND_FRAC-1:0] rsp_blends,
   output logic [REQ_INFOW-1:0]              rsp_info,
   output logic [31:0]                       perf_mem_reqs,
   output logic [31:0]                       perf_stall_cycles
);
   localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int PW = $clog2(MAX_PENDING);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   state_t state, state_nxt;

   logic [NUM_LANES-1:0]   mask_q;
   logic                   filter_q;
   logic [1:0]             lgstride_q;
   logic [W_ADDR_BITS-1:0] base_q [NUM_LANES];
   logic [31:0]            addr_q [NUM_LANES][4];
   logic [31:0]            tex_q  [NUM_LANES][4];
   logic [LW-1:0]          lane_q;
   logic [1:0]             tap_q;

   logic [LW-1:0] tag_lane [MAX_PENDING];
   logic [1:0]    tag_tap  [MAX_PENDING];
   logic [1:0]    tag_off  [MAX_PENDING];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] pending;

   logic                   req_fire, mreq_fire, mrsp_fire;
   logic [LW-1:0]          first_lane, next_lane;
   logic                   has_next, last_tap, last_pair;
   logic [W_ADDR_BITS-1:0] byte_addr;
   logic [1:0]             hd_off;
   logic [31:0]            texel;

   assign req_fire  = req_valid & req_ready;
   assign mreq_fire = mem_req_valid & mem_req_ready;
   assign mrsp_fire = mem_rsp_valid & mem_rsp_ready;

   // Lowest set lane wins: scan from the top down.
   always_comb begin
      first_lane = '0;
      next_lane  = '0;
      has_next   = 1'b0;
      for (int i = NUM_LANES-1; i >= 0; i--) begin
         if (req_mask[i]) first_lane = LW'(i);
         if (mask_q[i] && (i > int'(lane_q))) begin
            next_lane = LW'(i);
            has_next  = 1'b1;
         end
      end
   end

   assign last_tap  = !filter_q || (tap_q == 2'd3);
   assign last_pair = last_tap && !has_next;
   assign byte_addr = base_q[lane_q] + W_ADDR_BITS'(addr_q[lane_q][tap_q]);
   assign mem_req_addr = byte_addr[W_ADDR_BITS-1:2];

   always_comb begin
      hd_off = tag_off[rd_ptr];
      unique case (lgstride_q)
         2'd0:    texel = {24'd0, mem_rsp_data[{hd_off, 3'b000} +: 8]};
         2'd1:    texel = {16'd0, mem_rsp_data[{hd_off[1], 4'b0000} +: 16]};
         default: texel = mem_rsp_data;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // DRAIN looks at the post-response count so DONE follows the last fire.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (req_fire)
                   state_nxt = (req_mask == '0) ? DONE : ISSUE;
         ISSUE: if (mreq_fire && last_pair) state_nxt = DRAIN;
         DRAIN: if (pending == '0 || (pending == CW'(1) && mrsp_fire))
                   state_nxt = DONE;
         DONE:  if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready     = (state == IDLE);
      rsp_valid     = (state == DONE);
      mem_req_valid = (state == ISSUE) && (pending != CW'(MAX_PENDING));
      mem_rsp_ready = (pending != '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask_q     <= '0;
         filter_q   <= 1'b0;
         lgstride_q <= '0;
         lane_q     <= '0;
         tap_q      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         pending    <= '0;
         rsp_mask   <= '0;
         rsp_blends <= '0;
         rsp_info   <= '0;
         for (int l = 0; l < NUM_LANES; l++) begin
            base_q[l] <= '0;
            for (int t = 0; t < 4; t++) begin
               addr_q[l][t] <= '0;
               tex_q[l][t]  <= '0;
            end
         end
         for (int i = 0; i < MAX_PENDING; i++) begin
            tag_lane[i] <= '0;
            tag_tap[i]  <= '0;
            tag_off[i]  <= '0;
         end
      end else begin
         if (req_fire) begin
            mask_q     <= req_mask;
            filter_q   <= req_filter;
            lgstride_q <= req_lgstride;
            rsp_mask   <= req_mask;
            rsp_blends <= req_blends;
            rsp_info   <= req_info;
            lane_q     <= first_lane;
            tap_q      <= '0;
            for (int l = 0; l < NUM_LANES; l++) begin
               base_q[l] <= req_baseaddr[l*W_ADDR_BITS +: W_ADDR_BITS];
               for (int t = 0; t < 4; t++) begin
                  addr_q[l][t] <= req_addr[(l*4+t)*32 +: 32];
                  tex_q[l][t]  <= '0;
               end
            end
         end
         if (mreq_fire) begin
            tag_lane[wr_ptr] <= lane_q;
            tag_tap[wr_ptr]  <= tap_q;
            tag_off[wr_ptr]  <= byte_addr[1:0];
            wr_ptr           <= wr_ptr + 1'b1;
            if (last_tap) begin
               lane_q <= next_lane;
               tap_q  <= '0;
            end else begin
               tap_q <= tap_q + 2'd1;
            end
         end
         if (mrsp_fire) begin
            tex_q[tag_lane[rd_ptr]][tag_tap[rd_ptr]] <= texel;
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (mreq_fire != mrsp_fire)
            pending <= mreq_fire ? pending + 1'b1 : pending - 1'b1;
      end
   end

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      for (genvar t = 0; t < 4; t++) begin : g_tap
         assign rsp_texels[(l*4+t)*32 +: 32] = tex_q[l][t];
      end
   end

`ifdef TEX_FETCH_PERF_EN
   logic [31:0] perf_reqs_q, perf_stall_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_reqs_q  <= '0;
         perf_stall_q <= '0;
      end else begin
         if (mreq_fire)
            perf_reqs_q <= perf_reqs_q + 32'd1;
         if (mem_req_valid && !mem_req_ready)
            perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_mem_reqs     = perf_reqs_q;
   assign perf_stall_cycles = perf_stall_q;
`else
   assign perf_mem_reqs     = '0;
   assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_tex_texel_fetch.sv
// Bench for tex_texel_fetch: vector table, behavioural memory and
// texel model, plus latency, stall, hold and reset-in-drain sequences.
module tb_tex_texel_fetch;
   localparam int NL = 4;
   localparam int IW = 1;
   localparam int AW = 38;
   localparam int BF = 8;
   localparam int MP = 4;
   localparam int NV = 24;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 req_valid, req_ready;
   logic [NL-1:0]        req_mask;
   logic                 req_filter;
   logic [1:0]           req_lgstride;
   logic [NL*AW-1:0]     req_baseaddr;
   logic [NL*4*32-1:0]   req_addr;
   logic [NL*2*BF-1:0]   req_blends;
   logic [IW-1:0]        req_info;
   logic                 mem_req_valid, mem_req_ready;
   logic [AW-3:0]        mem_req_addr;
   logic                 mem_rsp_valid, mem_rsp_ready;
   logic [31:0]          mem_rsp_data;
   logic                 rsp_valid, rsp_ready;
   logic [NL-1:0]        rsp_mask;
   logic [NL*4*32-1:0]   rsp_texels;
   logic [NL*2*BF-1:0]   rsp_blends;
   logic [IW-1:0]        rsp_info;
   logic [31:0]          perf_mem_reqs, perf_stall_cycles;

   tex_texel_fetch #(
      .NUM_LANES(NL), .REQ_INFOW(IW), .W_ADDR_BITS(AW),
      .BLEND_FRAC(BF), .MAX_PENDING(MP)
   ) dut (
      .clk(clk), .reset(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_mask(req_mask), .req_filter(req_filter),
      .req_lgstride(req_lgstride), .req_baseaddr(req_baseaddr),
      .req_addr(req_addr), .req_blends(req_blends),
      .req_info(req_info),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
      .mem_rsp_data(mem_rsp_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_mask(rsp_mask), .rsp_texels(rsp_texels),
      .rsp_blends(rsp_blends), .rsp_info(rsp_info),
      .perf_mem_reqs(perf_mem_reqs),
      .perf_stall_cycles(perf_stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NL-1:0]             mask;
      logic                      filter;
      logic [1:0]                lg;
      logic [NL-1:0][AW-1:0]     base;
      logic [NL-1:0][3:0][31:0]  addr;
      logic [NL*2*BF-1:0]        blends;
      logic [IW-1:0]             info;
      int                        lat;
      bit                        rnd;
      int                        hold;
      bit                        stall5;
      logic [NL-1:0][3:0][31:0]  exp_tex;
      int                        exp_nreq;
   } vec_t;

   typedef struct {
      int          due;
      logic [31:0] data;
   } mrsp_t;

   vec_t          vecs [NV];
   mrsp_t         mq [$];
   logic [31:0]   mem_init [logic [35:0]];
   logic [35:0]   act_addrs [$];
   logic [35:0]   exp_addrs [$];
   int n_cmp = 0, n_bad = 0, cyc = 0;
   int lat = 0, force_low = 0, exp_total = 0;
   bit rnd_mem = 0;
   int out_cnt = 0, tb_reqs = 0, tb_stalls = 0, last_rsp_cyc = 0;
   bit prev_stall = 0, resume_due = 0;
   logic [35:0] prev_addr = '0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic logic [31:0] memword(logic [35:0] a);
      if (mem_init.exists(a)) return mem_init[a];
      return (a[31:0] * 32'h9E3779B1) ^ {a[35:32], 28'h5A5A5A5};
   endfunction

   // Reference: enumerate fetched taps in order, extract by stride.
   function automatic vec_t model(input vec_t v);
      logic [AW-1:0] b;
      logic [31:0]   w;
      int            off;
      v.exp_nreq = 0;
      v.exp_tex  = '0;
      for (int l = 0; l < NL; l++) begin
         if (!v.mask[l]) continue;
         for (int t = 0; t < (v.filter ? 4 : 1); t++) begin
            b   = v.base[l] + AW'(v.addr[l][t]);
            w   = memword(b[AW-1:2]);
            off = int'(b[1:0]);
            if (v.lg == 2'd0)      v.exp_tex[l][t] = (w >> (8*off)) & 32'hFF;
            else if (v.lg == 2'd1) v.exp_tex[l][t] = (w >> (16*(off/2))) & 32'hFFFF;
            else                   v.exp_tex[l][t] = w;
            v.exp_nreq++;
         end
      end
      return v;
   endfunction

   function automatic void build_addrs(input vec_t v);
      logic [AW-1:0] b;
      exp_addrs.delete();
      for (int l = 0; l < NL; l++)
         if (v.mask[l])
            for (int t = 0; t < (v.filter ? 4 : 1); t++) begin
               b = v.base[l] + AW'(v.addr[l][t]);
               exp_addrs.push_back(b[AW-1:2]);
            end
   endfunction

   // Memory: drives on negedge, observes handshakes 1 time unit later.
   initial begin
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (force_low > 0) begin
            mem_req_ready = 1'b0;
            force_low--;
         end else begin
            mem_req_ready = rnd_mem ? ($urandom_range(3) != 0) : 1'b1;
         end
         mem_rsp_valid = (mq.size() > 0) && (mq[0].due <= cyc) &&
                         !(rnd_mem && ($urandom_range(3) == 0));
         mem_rsp_data = (mq.size() > 0) ? mq[0].data : 32'h0;
         #1;
         if (!rst_n) begin
            mq.delete();
            out_cnt = 0; tb_reqs = 0; tb_stalls = 0;
            prev_stall = 0; resume_due = 0;
         end else begin
            chk("mem_rsp_ready", mem_rsp_ready, out_cnt != 0);
            if (out_cnt >= MP) chk("valid_at_full", mem_req_valid, 0);
            if (resume_due) chk("resume_after_rsp", mem_req_valid, 1);
            if (prev_stall) begin
               chk("stall_valid", mem_req_valid, 1);
               chk("stall_addr", mem_req_addr, prev_addr);
            end
            resume_due = 0;
            if (mem_req_valid && !mem_req_ready) tb_stalls++;
            prev_stall = mem_req_valid && !mem_req_ready;
            prev_addr  = mem_req_addr;
            if (mem_rsp_valid && mem_rsp_ready) begin
               if (out_cnt == MP && act_addrs.size() < exp_total) resume_due = 1;
               void'(mq.pop_front());
               out_cnt--;
               last_rsp_cyc = cyc;
            end
            if (mem_req_valid && mem_req_ready) begin
               mq.push_back('{due: cyc + lat, data: memword(mem_req_addr)});
               out_cnt++;
               tb_reqs++;
               act_addrs.push_back(mem_req_addr);
            end
         end
      end
   end

   task automatic check_reset_vals();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_mem_rsp_ready", mem_rsp_ready, 0);
      chk("rst_texels_zero", rsp_texels == '0, 1);
      chk("rst_rsp_mask", rsp_mask, 0);
      chk("rst_rsp_blends", rsp_blends, 0);
      chk("rst_rsp_info", rsp_info, 0);
      chk("rst_perf_reqs", perf_mem_reqs, 0);
      chk("rst_perf_stall", perf_stall_cycles, 0);
   endtask

   task automatic start_bundle(input vec_t v, output int a_cyc);
      lat = v.lat;
      rnd_mem = v.rnd;
      exp_total = v.exp_nreq;
      act_addrs.delete();
      build_addrs(v);
      @(negedge clk);
      req_valid    = 1'b1;
      req_mask     = v.mask;
      req_filter   = v.filter;
      req_lgstride = v.lg;
      req_baseaddr = v.base;
      req_addr     = v.addr;
      req_blends   = v.blends;
      req_info     = v.info;
      rsp_ready    = (v.hold == 0);
      #2;
      chk("req_ready_idle", req_ready, 1);
      a_cyc = cyc;
      if (v.stall5) force_low = 5;
      @(negedge clk);
      req_valid = 1'b0;
      req_mask  = $urandom;
      #2;
      chk("req_ready_busy", req_ready, 0);
      chk("first_mem_req", mem_req_valid, v.mask != 0);
   endtask

   task automatic run_bundle(input vec_t v);
      int a_cyc, n, st0;
      bit ok;
      logic [NL*4*32-1:0] snap;
      st0 = tb_stalls;
      start_bundle(v, a_cyc);
      n = 0;
      while (!rsp_valid && n < 3000) begin
         @(negedge clk); #2; n++;
      end
      if (!rsp_valid) begin
         chk("rsp_timeout", 0, 1);
         rsp_ready = 1'b1;
         return;
      end
      chk("rsp_latency", cyc, (v.mask == 0) ? a_cyc + 1 : last_rsp_cyc + 1);
      snap = rsp_texels;
      for (int i = 0; i < v.hold - 1; i++) begin
         @(negedge clk); #2;
         chk("hold_valid", rsp_valid, 1);
         chk("hold_texels", rsp_texels == snap, 1);
         chk("hold_mask", rsp_mask, v.mask);
      end
      if (v.hold > 0) begin
         @(negedge clk);
         rsp_ready = 1'b1;
         #2;
         chk("hold_end_valid", rsp_valid, 1);
      end
      chk("rsp_mask", rsp_mask, v.mask);
      chk("rsp_blends", rsp_blends, v.blends);
      chk("rsp_info", rsp_info, v.info);
      for (int l = 0; l < NL; l++)
         for (int t = 0; t < 4; t++)
            chk($sformatf("tex[%0d][%0d]", l, t),
                rsp_texels[(l*4+t)*32 +: 32], v.exp_tex[l][t]);
      @(negedge clk); #2;
      chk("idle_after_rsp", req_ready, 1);
      chk("rsp_valid_low", rsp_valid, 0);
      chk("nreq", act_addrs.size(), v.exp_nreq);
      ok = (act_addrs.size() == exp_addrs.size());
      for (int i = 0; ok && i < exp_addrs.size(); i++)
         if (act_addrs[i] !== exp_addrs[i]) ok = 0;
      chk("addr_order", ok, 1);
      if (v.stall5) chk("stall_cycles", tb_stalls - st0, 5);
`ifdef TEX_FETCH_PERF_EN
      chk("perf_reqs", perf_mem_reqs, tb_reqs);
      chk("perf_stall", perf_stall_cycles, tb_stalls);
`else
      chk("perf_reqs_off", perf_mem_reqs, 0);
      chk("perf_stall_off", perf_stall_cycles, 0);
`endif
   endtask

   function automatic vec_t rand_vec();
      vec_t v;
      v.mask   = NL'($urandom);
      v.filter = 1'($urandom);
      v.lg     = 2'($urandom_range(2));
      for (int l = 0; l < NL; l++) begin
         v.base[l] = ($urandom_range(3) == 0) ? {AW{1'b1}} - AW'($urandom_range(255))
                                              : AW'({$urandom, $urandom});
         for (int t = 0; t < 4; t++) v.addr[l][t] = $urandom;
      end
      v.blends = {$urandom, $urandom};
      v.info   = IW'($urandom);
      v.lat    = $urandom_range(6);
      v.rnd    = 1'b1;
      v.hold   = $urandom_range(2);
      v.stall5 = 1'b0;
      return model(v);
   endfunction

   initial begin
      vec_t v;
      int   a_cyc, n;
      req_valid = 0; req_mask = 0; req_filter = 0; req_lgstride = 0;
      req_baseaddr = '0; req_addr = '0; req_blends = '0; req_info = '0;
      rsp_ready = 1'b1;
      mem_init[36'h409] = 32'hDEADBEEF;
      mem_init[36'h800] = 32'h44332211;
      mem_init[36'hC00] = 32'hCAFEF00D;
      mem_init[36'hC40] = 32'h1234ABCD;

      for (int i = 0; i < NV; i++) vecs[i] = rand_vec();
      // Point sample, word stride
      v = vecs[0];
      v.mask = 4'b0001; v.filter = 0; v.lg = 2; v.rnd = 0; v.lat = 0;
      v.base[0] = 38'h1000; v.addr[0][0] = 32'h24; v.hold = 0;
      v.exp_tex = '0; v.exp_tex[0][0] = 32'hDEADBEEF; v.exp_nreq = 1;
      vecs[0] = v;
      // Bilinear byte stride, all lanes on one word
      v.mask = 4'b1111; v.filter = 1; v.lg = 0; v.exp_tex = '0;
      for (int l = 0; l < NL; l++) begin
         v.base[l] = 38'h2000;
         for (int t = 0; t < 4; t++) begin
            v.addr[l][t] = t;
            v.exp_tex[l][t] = 32'h11 * (t + 1);
         end
      end
      v.exp_nreq = 16;
      vecs[1] = v;
      // Halfword stride, alternate lanes
      v = vecs[2];
      v.mask = 4'b0101; v.filter = 1; v.lg = 1; v.rnd = 0; v.lat = 0;
      v.hold = 0;
      v.base[0] = 38'h3000; v.addr[0] = {32'd0, 32'd2, 32'd0, 32'd2};
      v.base[2] = 38'h3100; v.addr[2] = {32'd2, 32'd0, 32'd2, 32'd0};
      v.exp_tex = '0;
      v.exp_tex[0] = {32'hF00D, 32'hCAFE, 32'hF00D, 32'hCAFE};
      v.exp_tex[2] = {32'h1234, 32'hABCD, 32'h1234, 32'hABCD};
      v.exp_nreq = 8;
      vecs[2] = v;
      // Long latency, full bilinear
      v = vecs[3];
      v.mask = 4'b1111; v.filter = 1; v.lg = 2; v.rnd = 0; v.lat = 10;
      vecs[3] = model(v);
      // Memory stall then response back-pressure
      v = vecs[4];
      v.mask = 4'b0001; v.filter = 0; v.rnd = 0; v.lat = 0;
      v.hold = 3; v.stall5 = 1;
      vecs[4] = model(v);
      // Empty mask
      v = vecs[5];
      v.mask = 4'b0000; v.rnd = 0;
      vecs[5] = model(v);

      repeat (3) @(negedge clk);
      #2;
      check_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) run_bundle(vecs[i]);

      // Reset while draining outstanding reads
      v = rand_vec();
      v.mask = 4'b1111; v.filter = 0; v.rnd = 0; v.lat = 10; v.hold = 0;
      v = model(v);
      start_bundle(v, a_cyc);
      n = 0;
      while (act_addrs.size() < 4 && n < 200) begin
         @(negedge clk); #2; n++;
      end
      chk("drain_reached", act_addrs.size(), 4);
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      check_reset_vals();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #2;
      run_bundle(rand_vec());
      run_bundle(vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
